// File: rtl/key_matrix_scanner.sv
// 3x3 mole key matrix scanner: drives one column low at a time, debounces each key
// once per frame, and reports every new key-down as a single HIT/MISS event.
module key_matrix_scanner #(
  parameter int SCAN_TICKS     = 50000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [2:0] key_matrix_row,
  output logic [2:0] key_matrix_col,
  input  logic [8:0] lights,
  output logic [8:0] key_state,
  output logic       press_valid,
  output logic [3:0] press_index,
  output logic       hit,
  output logic       miss
);

  localparam int TW = (SCAN_TICKS > 1) ? $clog2(SCAN_TICKS) : 1;
  localparam int CW = (DEBOUNCE_SCANS > 0) ? $clog2(DEBOUNCE_SCANS + 1) : 1;
  localparam logic [TW-1:0] LAST_TICK = TW'(SCAN_TICKS - 1);
  localparam logic [CW-1:0] LAST_CNT  = CW'(DEBOUNCE_SCANS - 1);

  logic [TW-1:0]         tick;
  logic [1:0]            col_sel;
  logic [2:0]            sync_a;
  logic [2:0]            sync_b;
  logic [8:0][CW-1:0]    db_cnt;
  logic [8:0]            pending;

  logic                  sample;
  logic [8:0]            raw;
  logic [8:0]            due;
  logic [8:0]            state_next;
  logic [8:0][CW-1:0]    cnt_next;
  logic [8:0]            rise;
  logic                  sel_valid;
  logic [3:0]            sel_idx;
  logic [8:0]            clr;
  logic [8:0]            pending_next;

  // Rows are sampled on the last tick of a column so the synchroniser has settled.
  assign sample = (tick == LAST_TICK);

  always_comb begin
    raw = '0;
    due = '0;
    for (int i = 0; i < 9; i++) begin
      raw[i] = ~sync_b[i / 3];
      due[i] = sample && (col_sel == 2'(i % 3));
    end
  end

  always_comb begin
    state_next = key_state;
    cnt_next   = db_cnt;
    rise       = '0;
    for (int i = 0; i < 9; i++) begin
      if (due[i]) begin
        if (raw[i] == key_state[i]) begin
          cnt_next[i] = '0;
        end else if (db_cnt[i] == LAST_CNT) begin
          state_next[i] = ~key_state[i];
          cnt_next[i]   = '0;
          rise[i]       = ~key_state[i];
        end else begin
          cnt_next[i] = db_cnt[i] + CW'(1);
        end
      end
    end
  end

  // Lowest pending index wins; clr is its one-hot mask.
  always_comb begin
    sel_idx   = '0;
    clr       = '0;
    sel_valid = enable && (pending != '0);
    for (int i = 8; i >= 0; i--) begin
      if (pending[i]) begin
        sel_idx = 4'(i);
        clr     = '0;
        clr[i]  = 1'b1;
      end
    end
    pending_next = enable ? ((pending & ~clr) | rise) : '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tick           <= '0;
      col_sel        <= 2'd0;
      key_matrix_col <= 3'b110;
      sync_a         <= 3'b111;
      sync_b         <= 3'b111;
      key_state      <= '0;
      db_cnt         <= '0;
      pending        <= '0;
      press_valid    <= 1'b0;
      press_index    <= '0;
      hit            <= 1'b0;
      miss           <= 1'b0;
    end else begin
      sync_a <= key_matrix_row;
      sync_b <= sync_a;
      if (sample) begin
        tick           <= '0;
        col_sel        <= (col_sel == 2'd2) ? 2'd0 : col_sel + 2'd1;
        key_matrix_col <= {key_matrix_col[1:0], key_matrix_col[2]};
      end else begin
        tick <= tick + TW'(1);
      end
      key_state   <= state_next;
      db_cnt      <= cnt_next;
      pending     <= pending_next;
      press_valid <= sel_valid;
      hit         <= sel_valid && ((lights & clr) != '0);
      miss        <= sel_valid && ((lights & clr) == '0);
      if (sel_valid) begin
        press_index <= sel_idx;
      end
    end
  end

endmodule

// File: doc/key_matrix_scanner.md
Name: key_matrix_scanner

Overview:
Reads the player's whacks from the 3x3 mole key matrix. This is the input-side counterpart to the light controller, which drives the 9 mole LEDs.
- Scans columns, synchronises and debounces the row lines, and keeps a debounced key map.
- Emits one registered press event per new key-down, judged HIT or MISS against the current `lights[8:0]` vector.
- Sits between the `key_matrix_row` pins and the game FSM/score logic.

Parameters:
SCAN_TICKS, 50000, clk cycles each column is driven (1 ms at 50 MHz); minimum 4.
DEBOUNCE_SCANS, 4, consecutive agreeing samples (one per frame per key) needed to change a key's debounced state; minimum 1.

Ports:
clk  input  1  system clock, CLOCK_50 domain
reset  input  1  asynchronous, active-low reset
enable  input  1  1 = emit events; 0 = suppress events and flush pending
key_matrix_row  input  3  row lines, active-low (pulled up, 0 = pressed)
key_matrix_col  output  3  column drive, active-low one-cold
lights  input  9  currently lit moles, bit i = mole i
key_state  output  9  debounced pressed map, bit i = key i
press_valid  output  1  one-cycle pulse per reported press
press_index  output  4  key index 0..8 of reported press, held until next event
hit  output  1  pulse with press_valid when lights[press_index]=1
miss  output  1  pulse with press_valid when lights[press_index]=0

Behaviour:
- Key index = row*3 + col. Key i is pressed when column (i mod 3) is driven low and row (i/3) reads 0.
- Reset (async assert, sync release) values:
  - key_matrix_col=3'b110 (column 0)
  - tick counter=0
  - sync flops=3'b111
  - key_state=0, all debounce counters=0, pending=0
  - press_valid=hit=miss=0, press_index=0
- Row synchroniser: 2-flop on key_matrix_row; the raw pressed sample is the inverted sync output.
- Tick counter runs 0..SCAN_TICKS-1 and wraps to 0.
  - On the wrap cycle, the active column advances 0->1->2->0 and key_matrix_col rotates (110->101->011->110).
  - All outputs are registered; key_matrix_col changes one cycle after the wrap tick.
- Sampling: at tick==SCAN_TICKS-1, the 3 synced row bits are taken as raw samples for the 3 keys of the active column. The delay allows the synchroniser to settle.
  - A frame is 3*SCAN_TICKS cycles.
  - Each key is sampled exactly once per frame.
- Debounce, per key, counter width clog2(DEBOUNCE_SCANS+1), evaluated only at that key's sample:
  - If raw == key_state[i]: counter <= 0.
  - Else, if counter == DEBOUNCE_SCANS-1: key_state[i] flips and counter <= 0.
  - Else: counter increments.
  - An isolated glitch shorter than DEBOUNCE_SCANS frames never changes key_state.
- Pending: a 0->1 flip of key_state[i] sets pending[i]. A 1->0 flip (release) generates no event.
- Event emitter, each cycle:
  - If enable=1 and pending!=0, select the lowest set index k.
  - Next cycle: press_valid=1, press_index=k, hit=lights[k], miss=~lights[k], and pending[k] is cleared.
  - lights is sampled on the selection cycle, not the output cycle.
  - Otherwise press_valid=hit=miss=0 and press_index holds.
- Simultaneous presses (same column sample, or several pending): reported on consecutive cycles in ascending index order, one per cycle, none lost.
- A set and a clear of the same pending bit in one cycle: set wins. This is unreachable in practice and needs a release plus re-debounce.
- enable=0: pending is forced to 0 every cycle and no events are emitted. Scanning, debounce and key_state continue. Keys already held when enable rises are NOT reported.
- hit and miss are mutually exclusive; exactly one accompanies each press_valid.
- Reset mid-scan: all state returns to reset values immediately, a held key must re-debounce, and no event is emitted from pre-reset state.
- Worst-case press-to-event latency: 2 (sync) + 3*SCAN_TICKS*DEBOUNCE_SCANS + 2 cycles.

Test Plan:
Use SCAN_TICKS=4, DEBOUNCE_SCANS=2 (frame = 12 cycles).
1. Release reset, no keys -> key_matrix_col cycles 110,101,011 at 4-cycle intervals; key_state=0; no press_valid ever.
2. Model key 4 (row1/col1) held, lights=9'b000010000, enable=1 -> key_state[4]=1 after the 2nd col-1 sample; exactly one press_valid with press_index=4, hit=1, miss=0. Holding the key further produces no repeat.
3. Key 0 held, lights=0 -> single pulse, press_index=0, miss=1. Release -> key_state[0] clears after 2 frames with no event.
4. Key 3 pressed for only one col-0 sample, then released -> key_state[3] stays 0 and no event is emitted.
5. Keys 2, 5, 8 (same column) pressed together -> three press_valid pulses on consecutive cycles with indices 2, 5, 8.
6. Key 7 held while enable=0 until debounced, then enable=1 -> no event. Assert reset with key 7 held -> all outputs return to reset values, and the key is reported once after re-debounce.
